// File: rtl/mips_pcgen.sv
// rtl/mips_pcgen.sv - next-PC generator with return-address stack and jr miss counter
module mips_pcgen #(
  parameter int              WIDTH     = 32,
  parameter int              RAS_DEPTH = 8,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           stall,
  input  logic                           pcsrc,
  input  logic [WIDTH-1:0]               signimm,
  input  logic                           jump,
  input  logic                           jal,
  input  logic                           jr,
  input  logic [25:0]                    instr_index,
  input  logic [WIDTH-1:0]               rs_value,
  output logic [WIDTH-1:0]               pc,
  output logic [WIDTH-1:0]               pcplus4,
  output logic [WIDTH-1:0]               ras_top,
  output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
  output logic                           ras_pred_miss,
  output logic [15:0]                    miss_count
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(RAS_DEPTH);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [PTR_W-1:0] top_q, top_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pulse_q, pulse_d;
  logic [15:0]      miss_q, miss_d;

  // Stack entries carry no reset: validity is tracked solely by count_q.
  logic [WIDTH-1:0] ras_mem_q [RAS_DEPTH];
  logic             ras_we;
  logic [PTR_W-1:0] ras_waddr;
  logic             stack_empty;
  logic             miss;

  assign pcplus4     = pc_q + WIDTH'(4);
  assign stack_empty = (count_q == '0);
  assign ras_top     = stack_empty ? '0 : ras_mem_q[top_q];

  assign pc            = pc_q;
  assign ras_count     = count_q;
  assign ras_pred_miss = pulse_q;
  assign miss_count    = miss_q;

  // Next-PC select: jr beats jump/jal, which beat a taken branch.
  always_comb begin
    pc_d = pcplus4;
    if (jr) begin
      pc_d = rs_value;
    end else if (jump || jal) begin
      pc_d = {pcplus4[WIDTH-1:28], instr_index, 2'b00};
    end else if (pcsrc) begin
      pc_d = pcplus4 + (signimm << 2);
    end
  end

  // RAS push/pop/replace and jr prediction check against the pre-update top.
  always_comb begin
    top_d     = top_q;
    count_d   = count_q;
    ras_we    = 1'b0;
    ras_waddr = top_q + PTR_W'(1);
    miss      = jr && (stack_empty || (ras_top != rs_value));
    if (jal && (!jr || stack_empty)) begin
      // Plain push, or jalr on an empty stack; a full stack overwrites the oldest slot.
      ras_we = 1'b1;
      top_d  = top_q + PTR_W'(1);
      if (count_q != FULL) begin
        count_d = count_q + CNT_W'(1);
      end
    end else if (jal && jr) begin
      // jalr: consume the top as a return and push the new link in its place.
      ras_we    = 1'b1;
      ras_waddr = top_q;
    end else if (jr && !stack_empty) begin
      top_d   = top_q - PTR_W'(1);
      count_d = count_q - CNT_W'(1);
    end
    pulse_d = miss && !stall;
    miss_d  = (miss && (miss_q != 16'hFFFF)) ? miss_q + 16'd1 : miss_q;
  end

  // Architectural state: cleared asynchronously, frozen while stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      top_q   <= '0;
      count_q <= '0;
      miss_q  <= '0;
      pulse_q <= 1'b0;
    end else begin
      pulse_q <= pulse_d;
      if (!stall) begin
        pc_q    <= pc_d;
        top_q   <= top_d;
        count_q <= count_d;
        miss_q  <= miss_d;
      end
    end
  end

  // Stack entry write with the link address.
  always_ff @(posedge clk) begin
    if (ras_we && !stall && !reset) begin
      ras_mem_q[ras_waddr] <= pcplus4;
    end
  end

endmodule

// File: tb/tb_mips_pcgen.sv
// tb/tb_mips_pcgen.sv - scoreboard bench for mips_pcgen against a queue-based RAS model
module tb_mips_pcgen;
  localparam int          WIDTH     = 32;
  localparam int          RAS_DEPTH = 8;
  localparam logic [31:0] RESET_PC  = 32'h0;
  localparam int          CW        = $clog2(RAS_DEPTH + 1);

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b1;
  logic        pcsrc = 1'b0;
  logic        jump = 1'b0;
  logic        jal = 1'b0;
  logic        jr = 1'b0;
  logic [31:0] signimm = '0;
  logic [31:0] rs_value = '0;
  logic [25:0] instr_index = '0;
  logic [31:0] pc, pcplus4, ras_top;
  logic [CW-1:0] ras_count;
  logic        ras_pred_miss;
  logic [15:0] miss_count;

  mips_pcgen #(.WIDTH(WIDTH), .RAS_DEPTH(RAS_DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .stall(stall), .pcsrc(pcsrc), .signimm(signimm),
    .jump(jump), .jal(jal), .jr(jr), .instr_index(instr_index), .rs_value(rs_value),
    .pc(pc), .pcplus4(pcplus4), .ras_top(ras_top), .ras_count(ras_count),
    .ras_pred_miss(ras_pred_miss), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] top;
    logic [7:0]  cnt;
    logic        pulse;
    logic [15:0] miss;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: stack as a plain queue, newest entry at the back.
  logic [31:0] m_pc;
  logic [31:0] m_stack[$];
  int unsigned m_miss;
  bit          m_pulse;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_top();
    return (m_stack.size() > 0) ? m_stack[m_stack.size()-1] : 32'h0;
  endfunction

  task automatic model_reset();
    m_pc = RESET_PC;
    m_stack.delete();
    m_miss = 0;
    m_pulse = 0;
  endtask

  task automatic model_step(input bit s, input bit ps, input logic [31:0] si, input bit j,
                            input bit jl, input bit r, input logic [25:0] ix, input logic [31:0] rv);
    logic [31:0] link, nxt;
    bit hit;
    if (s) begin
      m_pulse = 0;
      return;
    end
    link = m_pc + 32'd4;
    if (r) nxt = rv;
    else if (j || jl) nxt = (link & 32'hF000_0000) | (32'(ix) * 32'd4);
    else if (ps) nxt = link + si * 32'd4;
    else nxt = link;
    hit = (m_stack.size() > 0) && (m_top() == rv);
    if (r && jl) begin
      if (m_stack.size() == 0) m_stack.push_back(link);
      else m_stack[m_stack.size()-1] = link;
    end else if (r) begin
      if (m_stack.size() > 0) void'(m_stack.pop_back());
    end else if (jl) begin
      m_stack.push_back(link);
      if (m_stack.size() > RAS_DEPTH) void'(m_stack.pop_front());
    end
    m_pulse = r && !hit;
    if (m_pulse && m_miss < 65535) m_miss++;
    m_pc = nxt;
  endtask

  // One clock of stimulus: drive at negedge, advance model, queue the post-edge expectation.
  task automatic cyc(input bit s, input bit ps, input logic [31:0] si, input bit j,
                     input bit jl, input bit r, input logic [25:0] ix, input logic [31:0] rv);
    exp_t e;
    @(negedge clk);
    stall = s; pcsrc = ps; signimm = si; jump = j; jal = jl; jr = r;
    instr_index = ix; rs_value = rv;
    model_step(s, ps, si, j, jl, r, ix, rv);
    e.pc = m_pc;
    e.top = m_top();
    e.cnt = 8'(m_stack.size());
    e.pulse = m_pulse;
    e.miss = 16'(m_miss);
    exp_q.push_back(e);
  endtask

  task automatic idle();
    cyc(0, 0, 32'h0, 0, 0, 0, 26'h0, 32'h0);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Monitor: every edge with a pending expectation is checked just after it.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("sb_pc", pc, e.pc);
      chk("sb_pcplus4", pcplus4, e.pc + 32'd4);
      chk("sb_ras_top", ras_top, e.top);
      chk("sb_ras_count", 32'(ras_count), 32'(e.cnt));
      chk("sb_pred_miss", 32'(ras_pred_miss), 32'(e.pulse));
      chk("sb_miss_count", 32'(miss_count), 32'(e.miss));
    end
  end

  initial begin
    logic [31:0] rv, si;
    int t;
    model_reset();
    #2;
    chk("rst_pc", pc, RESET_PC);
    chk("rst_ras_count", 32'(ras_count), 32'h0);
    chk("rst_miss_count", 32'(miss_count), 32'h0);
    chk("rst_pred_miss", 32'(ras_pred_miss), 32'h0);
    chk("rst_ras_top", ras_top, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_rst_pc", pc, 32'h0);

    // Free run
    idle(); settle(); chk("run_pc4", pc, 32'h4);
    idle(); settle(); chk("run_pc8", pc, 32'h8);
    idle(); settle(); chk("run_pc12", pc, 32'hC);

    // Backward branch and jump-over-branch priority
    cyc(0, 0, 32'h0, 1, 0, 0, 26'h10, 32'h0); settle(); chk("to_0x40", pc, 32'h40);
    cyc(0, 1, 32'hFFFF_FFFE, 0, 0, 0, 26'h0, 32'h0); settle(); chk("branch_back", pc, 32'h3C);
    cyc(0, 1, 32'h5, 1, 0, 0, 26'h100, 32'h0); settle(); chk("jump_over_branch", pc, 32'h400);

    // jal then matching jr
    cyc(0, 0, 32'h0, 1, 0, 0, 26'h4, 32'h0); settle(); chk("to_0x10", pc, 32'h10);
    cyc(0, 0, 32'h0, 0, 1, 0, 26'h40, 32'h0); settle(); chk("jal_top", ras_top, 32'h14);
    cyc(0, 0, 32'h0, 0, 0, 1, 26'h0, 32'h14); settle();
    chk("jr_hit_pc", pc, 32'h14);
    chk("jr_hit_count", 32'(ras_count), 32'h0);
    chk("jr_hit_pulse", 32'(ras_pred_miss), 32'h0);
    chk("jr_hit_miss", 32'(miss_count), 32'h0);

    // Overfill the stack, then unwind one past empty
    for (int i = 0; i < 9; i++) cyc(0, 0, 32'h0, 0, 1, 0, 26'h80, 32'h0);
    settle(); chk("ras_full", 32'(ras_count), 32'h8);
    for (int i = 0; i < 9; i++) begin
      rv = (m_stack.size() > 0) ? m_top() : 32'h204;
      cyc(0, 0, 32'h0, 0, 0, 1, 26'h0, rv);
      if (i == 7) begin
        settle();
        chk("unwind_hits", 32'(miss_count), 32'h0);
      end
    end
    settle();
    chk("unwind_empty_pulse", 32'(ras_pred_miss), 32'h1);
    chk("unwind_empty_miss", 32'(miss_count), 32'h1);

    // Mismatching jr, then stall across a jal
    cyc(0, 0, 32'h0, 1, 0, 0, 26'h3F, 32'h0); settle(); chk("to_0xfc", pc, 32'hFC);
    cyc(0, 0, 32'h0, 0, 1, 0, 26'hC0, 32'h0); settle(); chk("jal_top_100", ras_top, 32'h100);
    cyc(0, 0, 32'h0, 0, 0, 1, 26'h0, 32'h200); settle();
    chk("mis_pc", pc, 32'h200);
    chk("mis_pulse", 32'(ras_pred_miss), 32'h1);
    chk("mis_count_dec", 32'(ras_count), 32'h0);
    idle(); settle(); chk("mis_pulse_drop", 32'(ras_pred_miss), 32'h0);
    cyc(1, 0, 32'h0, 0, 1, 0, 26'h80, 32'h0); settle();
    chk("stall_pc", pc, 32'h204);
    chk("stall_count", 32'(ras_count), 32'h0);
    chk("stall_miss", 32'(miss_count), 32'h2);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      si = 32'($signed(12'($urandom)));
      rv = (($urandom % 2) == 1 && m_stack.size() > 0) ? m_top() : ($urandom & 32'hFFFF_FFFC);
      cyc(($urandom % 8) == 0, ($urandom % 3) == 0, si, ($urandom % 6) == 0,
          ($urandom % 4) == 0, ($urandom % 4) == 0, 26'($urandom), rv);
    end

    // Drive the miss counter into saturation
    while (m_miss != 65535) cyc(0, 0, 32'h0, 0, 0, 1, 26'h0, 32'h1000);
    for (int i = 0; i < 3; i++) cyc(0, 0, 32'h0, 0, 0, 1, 26'h0, 32'h1000);
    cyc(1, 0, 32'h0, 0, 0, 0, 26'h0, 32'h0);
    settle();
    chk("sat_miss", 32'(miss_count), 32'hFFFF);

    // Asynchronous reset between edges
    #1;
    reset = 1'b1;
    #1;
    model_reset();
    chk("async_rst_pc", pc, RESET_PC);
    chk("async_rst_miss", 32'(miss_count), 32'h0);
    chk("async_rst_count", 32'(ras_count), 32'h0);
    chk("async_rst_pulse", 32'(ras_pred_miss), 32'h0);
    chk("async_rst_top", ras_top, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("first_fetch", pc, RESET_PC);
    idle();
    idle();

    t = 0;
    while (exp_q.size() > 0 && t < 20) begin
      @(posedge clk);
      #2;
      t++;
    end
    if (exp_q.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
